lcd_seq_ctrl: RTL and testbench
===============================

Name: lcd_seq_ctrl

Overview:
Sequencer and owner of the shared spi_master byte channel for the LCD path.
- After reset it pulses the panel hardware reset, waits, then replays a power-up command/data/delay script from a small internal ROM into spi_master.
- Once the script completes, it hands the SPI channel to the drawing client (lcd_draw) as a gated pass-through.
- A re-init request replays the whole sequence without a global reset.

Parameters:
- RST_LOW_CYC, 100000: cycles lcd_rst_n is held low.
- RST_WAIT_CYC, 12000000: cycles waited after lcd_rst_n rises, before the first byte.
- DELAY_UNIT_CYC, 100000: cycles per unit of a script DELAY entry.
- INIT_LEN, 32: number of ROM entries; the pointer never exceeds INIT_LEN-1.
- CNT_W, 24: timer width. All *_CYC values must be < 2^CNT_W.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- reinit  in  1  one-cycle pulse requesting a full replay
- lcd_rst_n  out  1  panel hardware reset, active low
- init_done  out  1  high while the draw client owns SPI
- seq_state  out  3  encoded FSM state, for the LEDs
- draw_start  in  1  client byte start, one-cycle pulse
- draw_data  in  8  client byte
- draw_cmd  in  2  client byte type
- draw_ready  out  1  client may start a byte
- spi_start  out  1  to spi_master
- spi_data  out  8  to spi_master
- spi_cmd  out  2  to spi_master; 00 = command (DC low), 01 = data (DC high), others reserved
- spi_ready  in  1  from spi_master; high when idle, low from the cycle after spi_start until the byte is done

Behaviour:
Reset (reset == 0 at a clk edge):
- state = RST_LOW, lcd_rst_n = 0, init_done = 0, spi_start = 0, ROM pointer = 0, timers = 0.
- Reset mid-operation aborts everything immediately. A byte already in flight in spi_master is not waited for.

ROM entry format (10 bits, {type[1:0], payload[7:0]}):
- 00 = CMD byte, 01 = DATA byte.
- 10 = DELAY of payload × DELAY_UNIT_CYC cycles.
- 11 = END.

FSM states (seq_state encoding 0..7):
- RST_LOW: lcd_rst_n = 0 for exactly RST_LOW_CYC cycles, then go to RST_WAIT.
- RST_WAIT: lcd_rst_n = 1. Wait RST_WAIT_CYC cycles, then go to FETCH.
- FETCH (1 cycle): read rom[ptr].
  - CMD/DATA → ISSUE.
  - DELAY with payload 0 → advance ptr and stay in FETCH.
  - DELAY with payload ≠ 0 → DELAY.
  - END, or ptr == INIT_LEN-1 after executing that entry → RUN.
- ISSUE: wait for spi_ready == 1, then register spi_start = 1 for exactly one cycle with spi_data = payload and spi_cmd = type. Go to GUARD.
- GUARD (1 cycle): ignore spi_ready, then go to WAIT_DONE.
- WAIT_DONE: on spi_ready == 1, ptr++ and go to FETCH.
- DELAY: nested countdown, unit timer × payload counter, then ptr++ and go to FETCH.
- RUN:
  - init_done = 1.
  - Combinational pass-through: spi_start = draw_start, spi_data = draw_data, spi_cmd = draw_cmd, draw_ready = spi_ready.
  - In every other state, draw_ready = 0 and draw_start is ignored, not queued.

Reinit:
- reinit in RUN sets a pending flag.
- The pending flag is taken on the first cycle where spi_ready == 1 and draw_start == 0. That cycle moves to RST_LOW with ptr = 0 and init_done = 0 on the next cycle.
- If draw_start and reinit arrive in the same cycle, the draw byte is issued first and reinit stays pending.
- reinit outside RUN is ignored.

Outputs in non-RUN states:
- spi_data and spi_cmd hold their last issued values.
- spi_start = 0 except the single ISSUE pulse.

Latency:
- First script byte spi_start occurs exactly RST_LOW_CYC + RST_WAIT_CYC + 1 cycles after reset deasserts.
- Consecutive script bytes are separated by the spi_master byte time + 3 cycles (FETCH, ISSUE, GUARD).

Decomposition:
- Package lcd_pkg:
  - spi_cmd encodings (CMD_BYTE = 2'b00, DATA_BYTE = 2'b01).
  - ROM type encodings (T_CMD, T_DATA, T_DELAY, T_END).
  - State enum and its 3-bit seq_state encoding.
- Sub-module lcd_init_rom: combinational case-ROM, addr[$clog2(INIT_LEN)-1:0] → entry[9:0]. It holds the panel init script (SWRESET, delay, SLPOUT, delay, COLMOD + data, MADCTL + data, DISPON, END).

Test Plan (all runs use RST_LOW_CYC=4, RST_WAIT_CYC=6, DELAY_UNIT_CYC=3; the spi_master model takes 10 cycles per byte):
- Reset release → lcd_rst_n is low for 4 cycles, then high; first spi_start appears 11 cycles after reset deasserts, with spi_cmd=00 and spi_data=rom[0].
- Full script → the byte stream captured by the model equals the ROM CMD/DATA entries in order, with correct spi_cmd; init_done rises only after END.
- DELAY entry with payload 2 → the gap from the previous byte's spi_ready rise to the next spi_start is 6 + FETCH/ISSUE overhead; a payload-0 entry adds only 1 cycle.
- draw_start pulses before init_done → no spi_start and draw_ready = 0. After init_done, draw_start with draw_data=8'hA5 and draw_cmd=01 → spi_start appears the same cycle carrying A5/01.
- reinit pulsed while a draw byte is in flight → no abort. After spi_ready rises, lcd_rst_n drops on the next cycle and the script replays from entry 0. Same-cycle draw_start+reinit → the draw byte is sent first.
- reset asserted while in WAIT_DONE mid-script → all outputs return to their reset values on the next edge, and the sequence restarts from RST_LOW.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared encodings for the LCD sequencer: SPI byte types, init-ROM entry types and FSM states.
package lcd_pkg;

    localparam logic [1:0] CMD_BYTE  = 2'b00;
    localparam logic [1:0] DATA_BYTE = 2'b01;

    typedef enum logic [1:0] {
        T_CMD   = 2'b00,
        T_DATA  = 2'b01,
        T_DELAY = 2'b10,
        T_END   = 2'b11
    } rom_type_e;

    // The encoding doubles as the seq_state LED value.
    typedef enum logic [2:0] {
        S_RST_LOW   = 3'd0,
        S_RST_WAIT  = 3'd1,
        S_FETCH     = 3'd2,
        S_ISSUE     = 3'd3,
        S_GUARD     = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_DELAY     = 3'd6,
        S_RUN       = 3'd7
    } seq_state_e;

    function automatic logic [9:0] rom_entry(input rom_type_e t, input logic [7:0] payload);
        return {t, payload};
    endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Panel power-up script as a combinational case-ROM of {type, payload} entries.
module lcd_init_rom
    import lcd_pkg::*;
#(
    parameter int unsigned INIT_LEN = 32,
    parameter int unsigned AW       = $clog2(INIT_LEN)
) (
    input  logic [AW-1:0] addr,
    output logic [9:0]    entry
);

    always_comb begin
        // NOTE: the default arm covers every unlisted address, so no latch is inferred.
        case (int'(addr))
            0:       entry = rom_entry(T_CMD,   8'h01); // SWRESET
            1:       entry = rom_entry(T_DELAY, 8'd2);
            2:       entry = rom_entry(T_CMD,   8'h11); // SLPOUT
            3:       entry = rom_entry(T_DELAY, 8'd0);
            4:       entry = rom_entry(T_CMD,   8'h3A); // COLMOD
            5:       entry = rom_entry(T_DATA,  8'h55); // 16 bpp
            6:       entry = rom_entry(T_CMD,   8'h36); // MADCTL
            7:       entry = rom_entry(T_DATA,  8'h00);
            8:       entry = rom_entry(T_CMD,   8'h29); // DISPON
            default: entry = rom_entry(T_END,   8'h00);
        endcase
    end

endmodule

// File: rtl/lcd_seq_ctrl.sv
// LCD power-up sequencer: panel reset, ROM script replay into spi_master, then
// gated pass-through of the spi_master channel to the drawing client.
module lcd_seq_ctrl
    import lcd_pkg::*;
#(
    parameter int unsigned RST_LOW_CYC    = 100000,
    parameter int unsigned RST_WAIT_CYC   = 12000000,
    parameter int unsigned DELAY_UNIT_CYC = 100000,
    parameter int unsigned INIT_LEN       = 32,
    parameter int unsigned CNT_W          = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       reinit,
    output logic       lcd_rst_n,
    output logic       init_done,
    output logic [2:0] seq_state,
    input  logic       draw_start,
    input  logic [7:0] draw_data,
    input  logic [1:0] draw_cmd,
    output logic       draw_ready,
    output logic       spi_start,
    output logic [7:0] spi_data,
    output logic [1:0] spi_cmd,
    input  logic       spi_ready
);

    localparam int unsigned AW = $clog2(INIT_LEN);
    localparam logic [AW-1:0] LAST_PTR = AW'(INIT_LEN - 1);

    seq_state_e       state;
    logic [AW-1:0]    ptr;
    logic [CNT_W-1:0] timer;
    logic [7:0]       dly_cnt;
    logic             reinit_pend;
    logic             lcd_rst_q;
    logic             init_done_q;
    logic             start_q;
    logic [7:0]       data_q;
    logic [1:0]       cmd_q;

    logic [9:0]       entry;
    rom_type_e        etype;
    logic [7:0]       payload;
    logic             at_last;
    logic             take_reinit;

    lcd_init_rom #(.INIT_LEN(INIT_LEN), .AW(AW)) u_rom (
        .addr  (ptr),
        .entry (entry)
    );

    assign etype       = rom_type_e'(entry[9:8]);
    assign payload     = entry[7:0];
    assign at_last     = (ptr == LAST_PTR);
    assign take_reinit = (reinit_pend || reinit) && spi_ready && !draw_start;

    // NOTE: reset is sampled on the clock edge only, so it never appears in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_RST_LOW;
            ptr         <= '0;
            timer       <= '0;
            dly_cnt     <= '0;
            reinit_pend <= 1'b0;
            lcd_rst_q   <= 1'b0;
            init_done_q <= 1'b0;
            start_q     <= 1'b0;
            data_q      <= '0;
            cmd_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every read sees the pre-edge value.
            start_q <= 1'b0;
            case (state)
                S_RST_LOW: begin
                    lcd_rst_q <= 1'b0;
                    if (timer == CNT_W'(RST_LOW_CYC - 1)) begin
                        timer     <= '0;
                        lcd_rst_q <= 1'b1;
                        state     <= S_RST_WAIT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RST_WAIT: begin
                    if (timer == CNT_W'(RST_WAIT_CYC - 1)) begin
                        timer <= '0;
                        state <= S_FETCH;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_FETCH: begin
                    case (etype)
                        T_CMD, T_DATA: state <= S_ISSUE;
                        T_DELAY: begin
                            if (payload == 8'd0) begin
                                if (at_last) begin
                                    state       <= S_RUN;
                                    init_done_q <= 1'b1;
                                end else begin
                                    ptr   <= ptr + 1'b1;
                                    state <= S_FETCH;
                                end
                            end else begin
                                dly_cnt <= payload;
                                timer   <= '0;
                                state   <= S_DELAY;
                            end
                        end
                        default: begin
                            state       <= S_RUN;
                            init_done_q <= 1'b1;
                        end
                    endcase
                end
                S_ISSUE: begin
                    if (spi_ready) begin
                        start_q <= 1'b1;
                        data_q  <= payload;
                        cmd_q   <= entry[9:8];
                        state   <= S_GUARD;
                    end
                end
                // spi_ready only drops the cycle after spi_start, so it is still stale here.
                S_GUARD: state <= S_WAIT_DONE;
                S_WAIT_DONE: begin
                    if (spi_ready) begin
                        if (at_last) begin
                            state       <= S_RUN;
                            init_done_q <= 1'b1;
                        end else begin
                            ptr   <= ptr + 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                S_DELAY: begin
                    if (timer == CNT_W'(DELAY_UNIT_CYC - 1)) begin
                        timer <= '0;
                        if (dly_cnt == 8'd1) begin
                            if (at_last) begin
                                state       <= S_RUN;
                                init_done_q <= 1'b1;
                            end else begin
                                ptr   <= ptr + 1'b1;
                                state <= S_FETCH;
                            end
                        end else begin
                            dly_cnt <= dly_cnt - 1'b1;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin // S_RUN
                    if (draw_start) begin
                        data_q <= draw_data;
                        cmd_q  <= draw_cmd;
                    end
                    if (take_reinit) begin
                        state       <= S_RST_LOW;
                        ptr         <= '0;
                        timer       <= '0;
                        reinit_pend <= 1'b0;
                        lcd_rst_q   <= 1'b0;
                        init_done_q <= 1'b0;
                    end else if (reinit) begin
                        reinit_pend <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Client owns the channel only in RUN; elsewhere its strobes are dropped, not queued.
    assign spi_start  = (state == S_RUN) ? draw_start : start_q;
    assign spi_data   = (state == S_RUN) ? draw_data  : data_q;
    assign spi_cmd    = (state == S_RUN) ? draw_cmd   : cmd_q;
    assign draw_ready = (state == S_RUN) && spi_ready;
    assign lcd_rst_n  = lcd_rst_q;
    assign init_done  = init_done_q;
    assign seq_state  = state;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Directed bench for lcd_seq_ctrl with a 10-cycle-per-byte spi_master responder.
module tb_lcd_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       reinit = 1'b0;
    logic       draw_start = 1'b0;
    logic [7:0] draw_data = 8'h00;
    logic [1:0] draw_cmd = 2'b00;
    logic       lcd_rst_n, init_done, draw_ready, spi_start;
    logic [2:0] seq_state;
    logic [7:0] spi_data;
    logic [1:0] spi_cmd;
    logic       m_ready = 1'b1;

    int m_cnt = 0;
    bit prev_ready = 1'b1;
    int cyc = 0;
    logic [9:0] cap_q[$];
    int         start_cyc[$];
    int         rise_cyc[$];
    logic       cap_done[$];

    int n_checks = 0;
    int n_fail = 0;

    // Expected script bytes as {spi_cmd, spi_data}, and start gaps after the previous ready rise.
    logic [9:0] exp_bytes[7] = '{10'h001, 10'h011, 10'h03A, 10'h155, 10'h036, 10'h100, 10'h029};
    int         exp_gap[7]   = '{0, 10, 4, 3, 3, 3, 3};

    always #5 clk = ~clk;

    lcd_seq_ctrl #(
        .RST_LOW_CYC(4), .RST_WAIT_CYC(6), .DELAY_UNIT_CYC(3), .INIT_LEN(32), .CNT_W(24)
    ) dut (
        .clk(clk), .reset(reset), .reinit(reinit), .lcd_rst_n(lcd_rst_n),
        .init_done(init_done), .seq_state(seq_state), .draw_start(draw_start),
        .draw_data(draw_data), .draw_cmd(draw_cmd), .draw_ready(draw_ready),
        .spi_start(spi_start), .spi_data(spi_data), .spi_cmd(spi_cmd), .spi_ready(m_ready)
    );

    // spi_master model: ready low for 10 cycles starting the cycle after an accepted start.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (spi_start && m_ready) begin
            cap_q.push_back({spi_cmd, spi_data});
            start_cyc.push_back(cyc);
            cap_done.push_back(init_done);
            m_ready <= 1'b0;
            m_cnt   <= 9;
        end else if (!m_ready) begin
            if (m_cnt == 0) m_ready <= 1'b1;
            else            m_cnt   <= m_cnt - 1;
        end
        if (m_ready && !prev_ready) rise_cyc.push_back(cyc);
        prev_ready <= m_ready;
    end

    task automatic clear_logs();
        cap_q.delete(); start_cyc.delete(); rise_cyc.delete(); cap_done.delete();
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string what);
        int k = 0;
        while (seq_state !== s && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (seq_state !== s) begin
            n_checks++; n_fail++;
            $display("FAIL %s: timeout, seq_state=%0d required %0d", what, seq_state, s);
        end
    endtask

    task automatic wait_ready(input int bound, input string what);
        int k = 0;
        while (m_ready !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (m_ready !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL %s: timeout waiting spi_ready", what);
        end
    endtask

    task automatic wait_init_done(input int bound, input string what);
        int k = 0;
        while (init_done !== 1'b1 && k < bound) begin
            @(negedge clk);
            k++;
        end
        if (init_done !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL %s: timeout waiting init_done", what);
        end
    endtask

    // Called at a negedge with reset low. Latency is counted from the first edge sampling reset high.
    task automatic run_from_reset(output int low_cyc, output int lat);
        reset   = 1'b1;
        low_cyc = 0;
        lat     = -1;
        for (int k = 0; k < 40 && lat < 0; k++) begin
            if (k > 0) @(negedge clk);
            if (lcd_rst_n === 1'b0) low_cyc++;
            if (spi_start === 1'b1) lat = k - 1;
        end
    endtask

    task automatic test_reset();
        int low_cyc, lat;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (lcd_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset_lcd_rst_n: got %b required 0", lcd_rst_n); end
        n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done: got %b required 0", init_done); end
        n_checks++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL reset_spi_start: got %b required 0", spi_start); end
        n_checks++; if (seq_state !== 3'd0) begin n_fail++; $display("FAIL reset_seq_state: got %0d required 0", seq_state); end
        n_checks++; if (draw_ready !== 1'b0) begin n_fail++; $display("FAIL reset_draw_ready: got %b required 0", draw_ready); end
        clear_logs();
        run_from_reset(low_cyc, lat);
        n_checks++; if (low_cyc != 4) begin n_fail++; $display("FAIL rst_low_len: got %0d required 4", low_cyc); end
        n_checks++; if (lat != 11) begin n_fail++; $display("FAIL first_start_latency: got %0d required 11", lat); end
        n_checks++; if (spi_cmd !== 2'b00) begin n_fail++; $display("FAIL first_cmd: got %b required 00", spi_cmd); end
        n_checks++; if (spi_data !== 8'h01) begin n_fail++; $display("FAIL first_data: got %h required 01", spi_data); end
    endtask

    task automatic test_draw_gate();
        wait_state(3'd6, 40, "gate_wait_delay");
        draw_start = 1'b1; draw_data = 8'hFF; draw_cmd = 2'b01;
        #1;
        n_checks++; if (spi_start !== 1'b0) begin n_fail++; $display("FAIL gate_spi_start: got %b required 0", spi_start); end
        n_checks++; if (draw_ready !== 1'b0) begin n_fail++; $display("FAIL gate_draw_ready: got %b required 0", draw_ready); end
        @(negedge clk);
        draw_start = 1'b0;
    endtask

    task automatic test_script();
        wait_init_done(400, "script_init_done");
        repeat (5) @(negedge clk);
        n_checks++; if (cap_q.size() != 7) begin n_fail++; $display("FAIL script_count: got %0d required 7", cap_q.size()); end
        for (int i = 0; i < 7; i++) begin
            if (i < cap_q.size()) begin
                n_checks++;
                if (cap_q[i] !== exp_bytes[i]) begin n_fail++; $display("FAIL script_byte%0d: got %h required %h", i, cap_q[i], exp_bytes[i]); end
            end
        end
        for (int i = 1; i < 7; i++) begin
            if (i < start_cyc.size() && i - 1 < rise_cyc.size()) begin
                n_checks++;
                if (start_cyc[i] - rise_cyc[i-1] != exp_gap[i]) begin
                    n_fail++; $display("FAIL script_gap%0d: got %0d required %0d", i, start_cyc[i] - rise_cyc[i-1], exp_gap[i]);
                end
            end
        end
        if (cap_done.size() == 7) begin
            n_checks++; if (cap_done[6] !== 1'b0) begin n_fail++; $display("FAIL init_done_early: got %b required 0 at last byte", cap_done[6]); end
        end
        n_checks++; if (seq_state !== 3'd7) begin n_fail++; $display("FAIL run_state: got %0d required 7", seq_state); end
        n_checks++; if (draw_ready !== 1'b1) begin n_fail++; $display("FAIL run_draw_ready: got %b required 1", draw_ready); end
    endtask

    task automatic test_draw_pass();
        clear_logs();
        draw_start = 1'b1; draw_data = 8'hA5; draw_cmd = 2'b01;
        #1;
        n_checks++; if (spi_start !== 1'b1) begin n_fail++; $display("FAIL pass_start: got %b required 1", spi_start); end
        n_checks++; if (spi_data !== 8'hA5) begin n_fail++; $display("FAIL pass_data: got %h required a5", spi_data); end
        n_checks++; if (spi_cmd !== 2'b01) begin n_fail++; $display("FAIL pass_cmd: got %b required 01", spi_cmd); end
        @(negedge clk);
        draw_start = 1'b0;
        n_checks++; if (cap_q.size() != 1 || cap_q[0] !== 10'h1A5) begin n_fail++; $display("FAIL pass_capture: got %0d bytes, first %h required 1a5", cap_q.size(), cap_q.size() > 0 ? cap_q[0] : 10'h0); end
    endtask

    task automatic test_reinit_in_flight();
        reinit = 1'b1;
        @(negedge clk);
        reinit = 1'b0;
        n_checks++; if (seq_state !== 3'd7 || lcd_rst_n !== 1'b1) begin n_fail++; $display("FAIL reinit_no_abort: state %0d lcd_rst_n %b required 7/1", seq_state, lcd_rst_n); end
        wait_ready(20, "reinit_ready");
        n_checks++; if (lcd_rst_n !== 1'b1) begin n_fail++; $display("FAIL reinit_rst_early: got %b required 1", lcd_rst_n); end
        @(negedge clk);
        n_checks++; if (lcd_rst_n !== 1'b0) begin n_fail++; $display("FAIL reinit_rst_drop: got %b required 0", lcd_rst_n); end
        n_checks++; if (init_done !== 1'b0 || seq_state !== 3'd0) begin n_fail++; $display("FAIL reinit_state: init_done %b state %0d required 0/0", init_done, seq_state); end
        clear_logs();
        wait_init_done(400, "reinit_replay");
        n_checks++; if (cap_q.size() != 7 || cap_q[0] !== 10'h001) begin n_fail++; $display("FAIL reinit_replay: got %0d bytes, first %h required 7/001", cap_q.size(), cap_q.size() > 0 ? cap_q[0] : 10'h0); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        clear_logs();
        draw_start = 1'b1; reinit = 1'b1; draw_data = 8'h3C; draw_cmd = 2'b00;
        #1;
        n_checks++; if (spi_start !== 1'b1 || spi_data !== 8'h3C) begin n_fail++; $display("FAIL b2b_start: start %b data %h required 1/3c", spi_start, spi_data); end
        @(negedge clk);
        draw_start = 1'b0; reinit = 1'b0;
        n_checks++; if (seq_state !== 3'd7 || lcd_rst_n !== 1'b1) begin n_fail++; $display("FAIL b2b_pending: state %0d lcd_rst_n %b required 7/1", seq_state, lcd_rst_n); end
        wait_ready(20, "b2b_ready");
        @(negedge clk);
        n_checks++; if (lcd_rst_n !== 1'b0) begin n_fail++; $display("FAIL b2b_rst_drop: got %b required 0", lcd_rst_n); end
        n_checks++; if (cap_q.size() < 1 || cap_q[0] !== 10'h03C) begin n_fail++; $display("FAIL b2b_draw_first: got %0d bytes, first %h required 03c", cap_q.size(), cap_q.size() > 0 ? cap_q[0] : 10'h0); end
    endtask

    task automatic test_reset_mid();
        int low_cyc, lat;
        wait_state(3'd5, 60, "mid_wait_done");
        n_checks++; if (lcd_rst_n !== 1'b1) begin n_fail++; $display("FAIL mid_pre_rst: got %b required 1", lcd_rst_n); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (lcd_rst_n !== 1'b0) begin n_fail++; $display("FAIL mid_lcd_rst_n: got %b required 0", lcd_rst_n); end
        n_checks++; if (seq_state !== 3'd0) begin n_fail++; $display("FAIL mid_seq_state: got %0d required 0", seq_state); end
        n_checks++; if (spi_start !== 1'b0 || init_done !== 1'b0) begin n_fail++; $display("FAIL mid_outputs: start %b init_done %b required 0/0", spi_start, init_done); end
        @(negedge clk);
        run_from_reset(low_cyc, lat);
        n_checks++; if (low_cyc != 4) begin n_fail++; $display("FAIL mid_rst_low_len: got %0d required 4", low_cyc); end
        n_checks++; if (lat != 11 || spi_data !== 8'h01) begin n_fail++; $display("FAIL mid_restart: latency %0d data %h required 11/01", lat, spi_data); end
    endtask

    initial begin
        test_reset();
        test_draw_gate();
        test_script();
        test_draw_pass();
        test_reinit_in_flight();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
